divisor_32: RTL and testbench

DIVISOR_32 -- requirements
Module: divisor_32

---
 rtl/divisor_32.sv | 215 +++++++++++++++++++++
 tb/tb_divisor_32.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/divisor_32.sv
// Unsigned 32/32 restoring shift-subtract divider: one quotient bit per clock, result after 33 edges.
// Optional `done` result-valid flag is built only when DIVISOR_32_DONE_EN is defined.

// D flip-flop with asynchronous active-high reset and load enable
module dff_ar #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         r,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    always_ff @(posedge clk or posedge r) begin
        if (r)
            q <= '0;
        else if (en)
            q <= d;
    end
endmodule

// 2:1 multiplexer, sel=1 picks b
module mux2 #(
    parameter int W = 1
) (
    input  logic         sel,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] y
);
    assign y = sel ? b : a;
endmodule

// 32-bit adder/subtractor; in subtract mode cout=1 means no borrow (a >= b)
module resta32bits (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        sub,
    output logic [31:0] s,
    output logic        cout
);
    logic [32:0] sum;

    assign sum  = {1'b0, a} + {1'b0, b ^ {32{sub}}} + {32'd0, sub};
    assign s    = sum[31:0];
    assign cout = sum[32];
endmodule

module divisor_32 (
    input  logic        clk,
    input  logic        r,
    input  logic [31:0] dsor,
    input  logic [31:0] dend,
    output logic [31:0] quotient,
    output logic [31:0] remainder
`ifdef DIVISOR_32_DONE_EN
    ,
    output logic        done
`endif
);

    typedef enum logic [1:0] {
        S_LOAD,
        S_ITER,
        S_HOLD
    } state_t;

    state_t      state, state_nxt;
    logic [5:0]  cnt, cnt_nxt;
    logic        load, step, commit;

    logic [31:0] dsor_q;
    logic [31:0] qsh;
    logic [31:0] pr;

    logic [31:0] shifted_lo;
    logic        shifted_hi;
    logic [31:0] diff;
    logic        no_borrow;
    logic        take;
    logic [31:0] pr_step;
    logic [31:0] pr_d;
    logic [31:0] qsh_step;
    logic [31:0] qsh_d;

    always_ff @(posedge clk or posedge r) begin
        if (r) begin
            state <= S_LOAD;
            cnt   <= 6'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Counter runs 0 (load) -> 1..32 (iterate) -> 33 (hold until reset)
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        load      = 1'b0;
        step      = 1'b0;
        commit    = 1'b0;
        case (state)
            S_LOAD: begin
                load      = 1'b1;
                cnt_nxt   = 6'd1;
                state_nxt = S_ITER;
            end
            S_ITER: begin
                step    = 1'b1;
                cnt_nxt = cnt + 6'd1;
                if (cnt == 6'd32) begin
                    commit    = 1'b1;
                    state_nxt = S_HOLD;
                end
            end
            S_HOLD: begin
                state_nxt = S_HOLD;
            end
            default: begin
                state_nxt = S_LOAD;
                cnt_nxt   = 6'd0;
            end
        endcase
    end

    // The shifted partial remainder is 33 bits wide. Its top bit plus the subtractor's
    // no-borrow flag decide the sign of the 33-bit trial difference.
    assign shifted_lo = {pr[30:0], qsh[31]};
    assign shifted_hi = pr[31];

    resta32bits u_sub (
        .a    (shifted_lo),
        .b    (dsor_q),
        .sub  (1'b1),
        .s    (diff),
        .cout (no_borrow)
    );

    assign take     = shifted_hi | no_borrow;
    assign qsh_step = {qsh[30:0], take};

    mux2 #(.W(32)) u_pr_sel (
        .sel (take),
        .a   (shifted_lo),
        .b   (diff),
        .y   (pr_step)
    );

    mux2 #(.W(32)) u_pr_load (
        .sel (load),
        .a   (pr_step),
        .b   (32'd0),
        .y   (pr_d)
    );

    mux2 #(.W(32)) u_qsh_load (
        .sel (load),
        .a   (qsh_step),
        .b   (dend),
        .y   (qsh_d)
    );

    dff_ar #(.W(32)) u_dsor_reg (
        .clk (clk),
        .r   (r),
        .en  (load),
        .d   (dsor),
        .q   (dsor_q)
    );

    dff_ar #(.W(32)) u_qsh_reg (
        .clk (clk),
        .r   (r),
        .en  (load | step),
        .d   (qsh_d),
        .q   (qsh)
    );

    dff_ar #(.W(32)) u_pr_reg (
        .clk (clk),
        .r   (r),
        .en  (load | step),
        .d   (pr_d),
        .q   (pr)
    );

    // Outputs are written only on the final iteration so partial values never show
    dff_ar #(.W(32)) u_quot_reg (
        .clk (clk),
        .r   (r),
        .en  (commit),
        .d   (qsh_step),
        .q   (quotient)
    );

    dff_ar #(.W(32)) u_rem_reg (
        .clk (clk),
        .r   (r),
        .en  (commit),
        .d   (pr_step),
        .q   (remainder)
    );

`ifdef DIVISOR_32_DONE_EN
    dff_ar #(.W(1)) u_done_reg (
        .clk (clk),
        .r   (r),
        .en  (commit),
        .d   (1'b1),
        .q   (done)
    );
`endif

endmodule

// File: tb/tb_divisor_32.sv
// Directed self-checking bench for divisor_32; checks the done flag too when DIVISOR_32_DONE_EN is defined.
`timescale 1ns/1ps
module tb_divisor_32;

    logic        clk;
    logic        r;
    logic [31:0] dsor;
    logic [31:0] dend;
    logic [31:0] quotient;
    logic [31:0] remainder;
`ifdef DIVISOR_32_DONE_EN
    logic        done;
`endif

    int vectors;
    int miscompares;

    divisor_32 dut (
        .clk       (clk),
        .r         (r),
        .dsor      (dsor),
        .dend      (dend),
        .quotient  (quotient),
        .remainder (remainder)
`ifdef DIVISOR_32_DONE_EN
        ,
        .done      (done)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse reset between edges so the next rising edge is edge 1 (the load edge)
    task automatic start_div(input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        dend = a;
        dsor = b;
        r    = 1'b1;
        #2;
        r    = 1'b0;
    endtask

    task automatic edges(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        r = 1'b1; dend = 32'd108; dsor = 32'd31;
        #3;
        vectors++;
        if (quotient !== 32'd0) begin
            miscompares++;
            $display("[TB] FAIL reset_q got %h want %h", quotient, 32'd0);
        end
        vectors++;
        if (remainder !== 32'd0) begin
            miscompares++;
            $display("[TB] FAIL reset_r got %h want %h", remainder, 32'd0);
        end
`ifdef DIVISOR_32_DONE_EN
        vectors++;
        if (done !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_done got %b want 0", done);
        end
`endif
        edges(3);
        vectors++;
        if (quotient !== 32'd0) begin
            miscompares++;
            $display("[TB] FAIL reset_held_q got %h want %h", quotient, 32'd0);
        end
    endtask

    task automatic test_basic;
        start_div(32'd108, 32'd31);
        edges(1);
        dend = 32'hDEAD_BEEF;
        dsor = 32'd1;
        edges(31);
        vectors++;
        if (quotient !== 32'd0) begin
            miscompares++;
            $display("[TB] FAIL basic_edge32_q got %h want %h", quotient, 32'd0);
        end
        vectors++;
        if (remainder !== 32'd0) begin
            miscompares++;
            $display("[TB] FAIL basic_edge32_r got %h want %h", remainder, 32'd0);
        end
`ifdef DIVISOR_32_DONE_EN
        vectors++;
        if (done !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL basic_edge32_done got %b want 0", done);
        end
`endif
        edges(1);
        vectors++;
        if (quotient !== 32'd3) begin
            miscompares++;
            $display("[TB] FAIL basic_q got %h want %h", quotient, 32'd3);
        end
        vectors++;
        if (remainder !== 32'd15) begin
            miscompares++;
            $display("[TB] FAIL basic_r got %h want %h", remainder, 32'd15);
        end
`ifdef DIVISOR_32_DONE_EN
        vectors++;
        if (done !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL basic_done got %b want 1", done);
        end
`endif
    endtask

    task automatic test_max_by_one;
        start_div(32'hFFFF_FFFF, 32'd1);
        edges(33);
        vectors++;
        if (quotient !== 32'hFFFF_FFFF) begin
            miscompares++;
            $display("[TB] FAIL max_q got %h want %h", quotient, 32'hFFFF_FFFF);
        end
        vectors++;
        if (remainder !== 32'd0) begin
            miscompares++;
            $display("[TB] FAIL max_r got %h want %h", remainder, 32'd0);
        end
        edges(10);
        vectors++;
        if (quotient !== 32'hFFFF_FFFF) begin
            miscompares++;
            $display("[TB] FAIL max_hold_q got %h want %h", quotient, 32'hFFFF_FFFF);
        end
        vectors++;
        if (remainder !== 32'd0) begin
            miscompares++;
            $display("[TB] FAIL max_hold_r got %h want %h", remainder, 32'd0);
        end
`ifdef DIVISOR_32_DONE_EN
        vectors++;
        if (done !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL max_hold_done got %b want 1", done);
        end
`endif
    endtask

    task automatic test_corners;
        logic [31:0] tab_dend [4];
        logic [31:0] tab_dsor [4];
        logic [31:0] tab_q    [4];
        logic [31:0] tab_r    [4];
        tab_dend[0] = 32'd5;          tab_dsor[0] = 32'd7;          tab_q[0] = 32'd0;          tab_r[0] = 32'd5;
        tab_dend[1] = 32'h0000_1234;  tab_dsor[1] = 32'd0;          tab_q[1] = 32'hFFFF_FFFF;  tab_r[1] = 32'h0000_1234;
        tab_dend[2] = 32'hFFFF_FFFF;  tab_dsor[2] = 32'h8000_0001;  tab_q[2] = 32'd1;          tab_r[2] = 32'h7FFF_FFFE;
        tab_dend[3] = 32'd1000;       tab_dsor[3] = 32'd10;         tab_q[3] = 32'd100;        tab_r[3] = 32'd0;
        for (int i = 0; i < 4; i++) begin
            start_div(tab_dend[i], tab_dsor[i]);
            edges(33);
            vectors++;
            if (quotient !== tab_q[i]) begin
                miscompares++;
                $display("[TB] FAIL corner%0d_q got %h want %h", i, quotient, tab_q[i]);
            end
            vectors++;
            if (remainder !== tab_r[i]) begin
                miscompares++;
                $display("[TB] FAIL corner%0d_r got %h want %h", i, remainder, tab_r[i]);
            end
        end
    endtask

    task automatic test_abort;
        // A finished result must vanish as soon as reset asserts, without a clock edge
        @(negedge clk);
        r = 1'b1;
        #1;
        vectors++;
        if (quotient !== 32'd0 || remainder !== 32'd0) begin
            miscompares++;
            $display("[TB] FAIL async_clear got q=%h r=%h want 0/0", quotient, remainder);
        end
`ifdef DIVISOR_32_DONE_EN
        vectors++;
        if (done !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL async_clear_done got %b want 0", done);
        end
`endif
        #1;
        r = 1'b0;
        start_div(32'd100, 32'd7);
        edges(10);
        start_div(32'd50, 32'd7);
        edges(32);
        vectors++;
        if (quotient !== 32'd0) begin
            miscompares++;
            $display("[TB] FAIL abort_edge32_q got %h want %h", quotient, 32'd0);
        end
        edges(1);
        vectors++;
        if (quotient !== 32'd7) begin
            miscompares++;
            $display("[TB] FAIL abort_q got %h want %h", quotient, 32'd7);
        end
        vectors++;
        if (remainder !== 32'd1) begin
            miscompares++;
            $display("[TB] FAIL abort_r got %h want %h", remainder, 32'd1);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        r    = 1'b1;
        dend = 32'd0;
        dsor = 32'd0;
        test_reset();
        test_basic();
        test_max_by_one();
        test_corners();
        test_abort();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
